// File: rtl/char_ram_sequencer.sv
// Bulk clear / scroll-up / fill-row engine for the 80x30 text character RAM.
// Define CHAR_SEQ_SCROLL_EN to build the scroll-up operation (op 1).
module char_ram_sequencer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_row,
  input  logic [7:0]  cmd_char,
  input  logic [7:0]  cmd_attr,
  output logic        busy,
  output logic        done,
  output logic        cmd_err,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  output logic [11:0] ram_rd_addr,
  input  logic [7:0]  ram_rd_char,
  input  logic [7:0]  ram_rd_attr,
  output logic        ram_we,
  output logic [11:0] ram_wr_addr,
  output logic [7:0]  ram_wr_char,
  output logic [7:0]  ram_wr_attr
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [11:0] LastCell = 12'(CELLS - 1);
  localparam logic [11:0] LastRow  = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] ColsW    = 12'(COLS);
  localparam logic [4:0]  RowsW    = 5'(ROWS);

`ifdef CHAR_SEQ_SCROLL_EN
  localparam bit ScrEn = 1'b1;
`else
  localparam bit ScrEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, CLEAR, SCR_RD, SCR_WR, FILL, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] ptr_q, ptr_d;
  logic [11:0] end_q, end_d;
  logic [11:0] rd_addr_q, rd_addr_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;
  logic        errout_q, errout_d;

  logic        op_clr, op_scr, op_fill;
  logic [11:0] row_base;

  assign op_clr   = (cmd_op == 2'd0);
  assign op_scr   = ScrEn && (cmd_op == 2'd1);
  assign op_fill  = (cmd_op == 2'd2) && (cmd_row < RowsW);
  assign row_base = 12'(cmd_row) * ColsW;

`ifdef CHAR_SEQ_SCROLL_EN
  // a scroll write always owns the port so the read/write pair stays intact
  assign cpu_gnt = cpu_req && (state_q != SCR_WR);
`else
  assign cpu_gnt = cpu_req;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    end_d     = end_q;
    rd_addr_d = rd_addr_q;
    char_d    = char_q;
    attr_d    = attr_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_q) begin
          char_d = cmd_char;
          attr_d = cmd_attr;
          err_d  = 1'b0;
          unique case (1'b1)
            op_clr: begin
              state_d = CLEAR;
              ptr_d   = '0;
              end_d   = LastCell;
            end
            op_scr: begin
              state_d   = SCR_RD;
              ptr_d     = '0;
              rd_addr_d = ColsW;
            end
            op_fill: begin
              state_d = FILL;
              ptr_d   = row_base;
              end_d   = row_base + ColsW - 12'd1;
            end
            default: begin
              state_d = DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      CLEAR, FILL: begin
        if (!cpu_gnt) begin
          if (ptr_q == end_q) state_d = DONE;
          else ptr_d = ptr_q + 12'd1;
        end
      end
      SCR_RD: begin
        if (!cpu_gnt) state_d = SCR_WR;
      end
      SCR_WR: begin
        if (ptr_q == LastRow - 12'd1) begin
          state_d = FILL;
          ptr_d   = LastRow;
          end_d   = LastCell;
        end else begin
          state_d   = SCR_RD;
          ptr_d     = ptr_q + 12'd1;
          rd_addr_d = ptr_q + ColsW + 12'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d   = (state_d == CLEAR) || (state_d == SCR_RD) ||
               (state_d == SCR_WR) || (state_d == FILL);
    done_d   = (state_d == DONE);
    rdy_d    = (state_d == IDLE);
    errout_d = (state_d == DONE) && err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      end_q     <= '0;
      rd_addr_q <= '0;
      char_q    <= '0;
      attr_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b1;
      errout_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      end_q     <= end_d;
      rd_addr_q <= rd_addr_d;
      char_q    <= char_d;
      attr_q    <= attr_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
      errout_q  <= errout_d;
    end
  end

  logic wr_state;
  logic scr_wr;

  assign wr_state = (state_q == CLEAR) || (state_q == FILL) ||
                    (state_q == SCR_WR);
  assign scr_wr   = ScrEn && (state_q == SCR_WR);

  assign cmd_ready   = rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_err     = errout_q;
  assign ram_we      = wr_state && !cpu_gnt;
  assign ram_wr_addr = ptr_q;
  assign ram_wr_char = scr_wr ? ram_rd_char : char_q;
  assign ram_wr_attr = scr_wr ? ram_rd_attr : attr_q;
  assign ram_rd_addr = ScrEn ? rd_addr_q : 12'd0;

endmodule

// File: tb/tb_char_ram_sequencer.sv
// Randomized bench for char_ram_sequencer against a cell-level screen model.
// Scroll expectations follow CHAR_SEQ_SCROLL_EN.
module tb_char_ram_sequencer;

  localparam int CELLS = 2400;
  localparam int COLS  = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_row;
  logic [7:0]  cmd_char, cmd_attr;
  logic        busy, done, cmd_err;
  logic        cpu_req, cpu_gnt;
  logic [11:0] ram_rd_addr, ram_wr_addr;
  logic [7:0]  rd_char, rd_attr;
  logic        ram_we;
  logic [7:0]  ram_wr_char, ram_wr_attr;

  always #5 clk = ~clk;

  char_ram_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row),
    .cmd_char(cmd_char), .cmd_attr(cmd_attr),
    .busy(busy), .done(done), .cmd_err(cmd_err),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_char(rd_char), .ram_rd_attr(rd_attr),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_char(ram_wr_char), .ram_wr_attr(ram_wr_attr)
  );

  logic [15:0] mem  [CELLS];
  logic [15:0] refm [CELLS];
  int wr_total  = 0;
  int viol_gnt  = 0;
  int viol_addr = 0;
  bit pre_go = 1'b0;
  int pre_mode = 0;

  // RAM model: preload port, engine write port, 1-cycle read port
  always @(posedge clk) begin
    if (pre_go) begin
      for (int i = 0; i < CELLS; i++)
        if (pre_mode == 1) mem[i] <= {i[7:0], ~i[7:0]};
        else mem[i] <= 16'($urandom);
    end else if (ram_we) begin
      wr_total <= wr_total + 1;
      if (cpu_gnt) viol_gnt <= viol_gnt + 1;
      if (ram_wr_addr < 12'(CELLS)) mem[ram_wr_addr] <= {ram_wr_char, ram_wr_attr};
      else viol_addr <= viol_addr + 1;
    end
    if (ram_rd_addr < 12'(CELLS)) {rd_char, rd_attr} <= mem[ram_rd_addr];
    else {rd_char, rd_attr} <= 16'h0;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"}, cmd_ready, 1);
    chk({tag, "_busy_done_err"}, {busy, done, cmd_err}, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_addr"}, {ram_rd_addr, ram_wr_addr}, 0);
    chk({tag, "_data"}, {ram_wr_char, ram_wr_attr}, 0);
  endtask

  task automatic preload(input int mode);
    pre_mode = mode;
    pre_go = 1'b1;
    @(posedge clk);
    #1 pre_go = 1'b0;
  endtask

  // op: command; creq_pct: random CPU contention; burst: cycle to start an
  // 11-cycle cpu_req burst (0 = none); exp_g: expected grant count (-1 = any)
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [4:0] row, input logic [7:0] c,
                        input logic [7:0] a, input int creq_pct,
                        input int burst, input int exp_g);
    int base, exp_wr, exp_err, cyc, gcnt, bad, wr0, vg0, va0, dcyc, miss;
    bit seen, derr;
    for (int i = 0; i < CELLS; i++) refm[i] = mem[i];
    exp_err = 0;
    if (op == 2'd0) begin
      base = CELLS + 1; exp_wr = CELLS;
      for (int i = 0; i < CELLS; i++) refm[i] = {c, a};
`ifdef CHAR_SEQ_SCROLL_EN
    end else if (op == 2'd1) begin
      base = 2 * (CELLS - COLS) + COLS + 1; exp_wr = CELLS;
      for (int i = 0; i < CELLS; i++)
        refm[i] = (i < CELLS - COLS) ? mem[i + COLS] : {c, a};
`endif
    end else if (op == 2'd2 && row < 5'd30) begin
      base = COLS + 1; exp_wr = COLS;
      for (int i = 0; i < COLS; i++) refm[int'(row) * COLS + i] = {c, a};
    end else begin
      base = 1; exp_wr = 0; exp_err = 1;
    end
    wr0 = wr_total; vg0 = viol_gnt; va0 = viol_addr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row;
    cmd_char = c; cmd_attr = a;
    @(posedge clk);
    cyc = 0; gcnt = 0; bad = 0; seen = 0; dcyc = 0; derr = 0;
    while (!seen && cyc < 20000) begin
      #1;
      cyc++;
      // keep requesting a different command while busy; it must be ignored
      cmd_op = 2'd0; cmd_char = ~c;
      if (burst > 0) cpu_req = (cyc >= burst && cyc <= burst + 10);
      else cpu_req = ($urandom_range(0, 99) < creq_pct);
      @(negedge clk);
      if (burst > 0 && cyc == burst && op == 2'd1)
        chk({tag, "_gnt_scr_wr"}, cpu_gnt, 0);
      if (busy && cpu_gnt) gcnt++;
      if (busy && cmd_ready) bad++;
      if (done) begin
        seen = 1; dcyc = cyc; derr = cmd_err;
      end
      @(posedge clk);
    end
    #1;
    cmd_valid = 1'b0; cpu_req = 1'b0;
    if (!seen) chk({tag, "_done_seen"}, 0, 1);
    chk({tag, "_done_cyc"}, dcyc, base + gcnt);
    chk({tag, "_err"}, derr, exp_err);
    chk({tag, "_writes"}, wr_total - wr0, exp_wr);
    chk({tag, "_we_while_gnt"}, viol_gnt - vg0, 0);
    chk({tag, "_addr_range"}, viol_addr - va0, 0);
    chk({tag, "_ready_busy"}, bad, 0);
    if (exp_g >= 0) chk({tag, "_gnt_cycles"}, gcnt, exp_g);
    @(posedge clk);
    #1;
    miss = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== refm[i]) miss++;
    chk({tag, "_mem"}, miss, 0);
    chk({tag, "_idle"}, {cmd_ready, busy}, 2'b10);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0;
    cmd_char = '0; cmd_attr = '0; cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    rst_n = 1'b1;
    preload(2);

    run_op("clear", 2'd0, 5'd0, 8'h20, 8'h07, 0, 0, 0);
    preload(2);
    run_op("fill29", 2'd2, 5'd29, 8'h41, 8'h70, 0, 0, 0);
    run_op("fill30", 2'd2, 5'd30, 8'h41, 8'h70, 0, 0, 0);
    run_op("op3", 2'd3, 5'd3, 8'h11, 8'h22, 0, 0, 0);
    preload(1);
`ifdef CHAR_SEQ_SCROLL_EN
    run_op("scroll", 2'd1, 5'd0, 8'h2E, 8'h1F, 0, 0, 0);
    preload(1);
    run_op("scroll_cpu", 2'd1, 5'd0, 8'h2E, 8'h1F, 0, 100, 10);
`else
    run_op("scroll_off", 2'd1, 5'd0, 8'h2E, 8'h1F, 0, 0, 0);
    preload(2);
    run_op("clear_cpu", 2'd0, 5'd0, 8'h55, 8'hAA, 0, 100, 11);
`endif

    for (int n = 0; n < 6; n++) begin
      preload(2);
      run_op("rand", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             8'($urandom), 8'($urandom), 25, 0, -1);
    end

    // asynchronous reset in the middle of a clear
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_char = 8'h33; cmd_attr = 8'h44;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (499) @(posedge clk);
    #1 chk("mid_we", ram_we, 1);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_op("clear_after_rst", 2'd0, 5'd0, 8'h20, 8'h07, 10, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
